// File: rtl/xnor_gate.sv
// rtl/xnor_gate.sv - bitwise XNOR with registered result, equality statistics and match counter
module xnor_gate #(
   parameter int WIDTH = 1,
   parameter int CNT_W = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [WIDTH-1:0]           I1,
   input  logic [WIDTH-1:0]           I2,
   input  logic                       in_valid,
   input  logic                       clr,
   output logic [WIDTH-1:0]           O,
   output logic [WIDTH-1:0]           O_q,
   output logic                       out_valid,
   output logic                       all_eq,
   output logic [$clog2(WIDTH+1)-1:0] ones_cnt,
   output logic [CNT_W-1:0]           match_cnt
);

   localparam int OC_W = $clog2(WIDTH+1);

   // bit-equality vector of the live operands and its statistics
   logic [WIDTH-1:0] eq_vec;
   logic             eq_all;
   logic [OC_W-1:0]  eq_ones;

   // next-state values for the registered path
   logic [WIDTH-1:0] xnor_d,  xnor_q;
   logic             valid_d, valid_q;
   logic             alleq_d, alleq_q;
   logic [OC_W-1:0]  ones_d,  ones_q;
   logic [CNT_W-1:0] match_d, match_q;

   // live XNOR; also drives O so the gate output ignores reset and valid
   assign eq_vec = ~(I1 ^ I2);
   assign eq_all = &eq_vec;
   assign O      = eq_vec;

   // population count of matching bit positions, sized to hold WIDTH
   always_comb begin
      eq_ones = '0;
      for (int i = 0; i < WIDTH; i++) begin
         eq_ones = eq_ones + OC_W'(eq_vec[i]);
      end
   end

   // capture the sample statistics only when the inputs are qualified
   always_comb begin
      xnor_d  = xnor_q;
      alleq_d = alleq_q;
      ones_d  = ones_q;
      valid_d = in_valid;
      if (in_valid) begin
         xnor_d  = eq_vec;
         alleq_d = eq_all;
         ones_d  = eq_ones;
      end
   end

   // match counter: clear wins over a matching sample, increment saturates
   always_comb begin
      match_d = match_q;
      if (clr) begin
         match_d = '0;
      end else if (in_valid && eq_all && (match_q != {CNT_W{1'b1}})) begin
         match_d = match_q + CNT_W'(1);
      end
   end

   // state registers; reset clears everything, discarding an in-flight sample
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         xnor_q  <= '0;
         valid_q <= 1'b0;
         alleq_q <= 1'b0;
         ones_q  <= '0;
         match_q <= '0;
      end else begin
         xnor_q  <= xnor_d;
         valid_q <= valid_d;
         alleq_q <= alleq_d;
         ones_q  <= ones_d;
         match_q <= match_d;
      end
   end

   assign O_q       = xnor_q;
   assign out_valid = valid_q;
   assign all_eq    = alleq_q;
   assign ones_cnt  = ones_q;
   assign match_cnt = match_q;

endmodule

// File: tb/tb_xnor_gate.sv
// tb/tb_xnor_gate.sv - randomized and directed checks of xnor_gate against a behavioural model
module tb_xnor_gate;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   // instance A: WIDTH=8, CNT_W=2
   logic [7:0] a_i1 = '0, a_i2 = '0;
   logic       a_vld = 1'b0, a_clr = 1'b0;
   logic [7:0] a_o, a_oq;
   logic       a_ov, a_eq;
   logic [3:0] a_ones;
   logic [1:0] a_cnt;

   // instance B: WIDTH=1, CNT_W=4
   logic       b_i1 = 1'b0, b_i2 = 1'b0;
   logic       b_vld = 1'b0, b_clr = 1'b0;
   logic       b_o, b_oq, b_ov, b_eq, b_ones;
   logic [3:0] b_cnt;

   int errs = 0;
   int checks = 0;

   xnor_gate #(.WIDTH(8), .CNT_W(2)) u_a (
      .clk(clk), .rst_n(rst_n), .I1(a_i1), .I2(a_i2), .in_valid(a_vld), .clr(a_clr),
      .O(a_o), .O_q(a_oq), .out_valid(a_ov), .all_eq(a_eq), .ones_cnt(a_ones), .match_cnt(a_cnt)
   );

   xnor_gate #(.WIDTH(1), .CNT_W(4)) u_b (
      .clk(clk), .rst_n(rst_n), .I1(b_i1), .I2(b_i2), .in_valid(b_vld), .clr(b_clr),
      .O(b_o), .O_q(b_oq), .out_valid(b_ov), .all_eq(b_eq), .ones_cnt(b_ones), .match_cnt(b_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // per-bit equality written as an explicit comparison per position
   function automatic logic [7:0] eq_bits(input logic [7:0] x, input logic [7:0] y);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = (x[i] == y[i]) ? 1'b1 : 1'b0;
      return r;
   endfunction

   function automatic int n_equal(input logic [7:0] x, input logic [7:0] y);
      int n = 0;
      for (int i = 0; i < 8; i++) if (x[i] == y[i]) n++;
      return n;
   endfunction

   // behavioural model state
   logic [7:0] ma_oq = '0;
   logic       ma_ov = 1'b0, ma_eq = 1'b0;
   int         ma_ones = 0, ma_cnt = 0;
   logic       mb_oq = 1'b0, mb_ov = 1'b0;
   int         mb_cnt = 0;

   // model: last valid sample statistics and a clamped integer match count
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ma_oq = '0; ma_ov = 1'b0; ma_eq = 1'b0; ma_ones = 0; ma_cnt = 0;
         mb_oq = 1'b0; mb_ov = 1'b0; mb_cnt = 0;
      end else begin
         ma_ov = a_vld;
         if (a_clr) ma_cnt = 0;
         else if (a_vld && a_i1 == a_i2) ma_cnt = (ma_cnt + 1 > 3) ? 3 : ma_cnt + 1;
         if (a_vld) begin
            ma_oq   = eq_bits(a_i1, a_i2);
            ma_eq   = (a_i1 == a_i2);
            ma_ones = n_equal(a_i1, a_i2);
         end
         mb_ov = b_vld;
         if (b_clr) mb_cnt = 0;
         else if (b_vld && b_i1 == b_i2) mb_cnt = (mb_cnt + 1 > 15) ? 15 : mb_cnt + 1;
         if (b_vld) mb_oq = (b_i1 == b_i2);
      end
   end

   // compare process: every falling edge, all outputs against the model
   always @(negedge clk) begin
      chk("a_O", a_o, eq_bits(a_i1, a_i2));
      chk("a_O_q", a_oq, ma_oq);
      chk("a_out_valid", a_ov, ma_ov);
      chk("a_all_eq", a_eq, ma_eq);
      chk("a_ones_cnt", a_ones, ma_ones);
      chk("a_match_cnt", a_cnt, ma_cnt);
      chk("b_O", b_o, (b_i1 == b_i2));
      chk("b_O_q", b_oq, mb_oq);
      chk("b_out_valid", b_ov, mb_ov);
      chk("b_all_eq", b_eq, mb_oq);
      chk("b_ones_cnt", b_ones, mb_oq);
      chk("b_match_cnt", b_cnt, mb_cnt);
   end

   task automatic drive_a(input logic [7:0] x, input logic [7:0] y, input logic v, input logic c);
      @(negedge clk);
      #1;
      a_i1 = x; a_i2 = y; a_vld = v; a_clr = c;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      // reset state and WIDTH=1 truth table while reset is held
      #2;
      chk("rst_O_q", a_oq, 8'h00);
      chk("rst_out_valid", a_ov, 0);
      chk("rst_all_eq", a_eq, 0);
      chk("rst_ones_cnt", a_ones, 0);
      chk("rst_match_cnt", a_cnt, 0);
      b_i1 = 0; b_i2 = 1; #1 chk("w1_01", b_o, 0);
      b_i1 = 1; b_i2 = 1; #1 chk("w1_11", b_o, 1);
      b_i1 = 0; b_i2 = 0; #1 chk("w1_00", b_o, 1);
      b_i1 = 1; b_i2 = 0; #1 chk("w1_10", b_o, 0);
      @(negedge clk);
      #1 rst_n = 1'b1;

      // single mismatching sample
      drive_a(8'hA5, 8'hA4, 1, 0);
      tick;
      chk("a5_O_q", a_oq, 8'hFE);
      chk("a5_ones", a_ones, 7);
      chk("a5_all_eq", a_eq, 0);
      chk("a5_out_valid", a_ov, 1);
      chk("a5_match", a_cnt, 0);
      drive_a(8'h00, 8'hFF, 0, 0);
      tick;
      chk("a5_ov_drop", a_ov, 0);
      chk("a5_hold", a_oq, 8'hFE);

      // three back-to-back matches
      for (int k = 1; k <= 3; k++) begin
         drive_a(8'h3C, 8'h3C, 1, 0);
         tick;
         chk("3c_all_eq", a_eq, 1);
         chk("3c_ones", a_ones, 8);
         chk("3c_ov", a_ov, 1);
         chk("3c_match", a_cnt, k);
      end
      drive_a(8'h12, 8'h34, 0, 0);
      tick;
      chk("3c_hold_oq", a_oq, 8'hFF);
      chk("3c_hold_ov", a_ov, 0);
      chk("3c_hold_eq", a_eq, 1);
      chk("3c_hold_cnt", a_cnt, 3);

      // saturation at 3 and clear priority
      drive_a(8'h00, 8'h00, 0, 1);
      tick;
      chk("clr_idle", a_cnt, 0);
      for (int k = 1; k <= 5; k++) begin
         drive_a(8'(k * 37), 8'(k * 37), 1, 0);
         tick;
         chk("sat_match", a_cnt, (k > 3) ? 3 : k);
      end
      drive_a(8'h77, 8'h77, 1, 1);
      tick;
      chk("clr_prio", a_cnt, 0);
      chk("clr_capture", a_eq, 1);

      // asynchronous reset between edges with out_valid=1 and match_cnt=2
      drive_a(8'h5A, 8'h5A, 1, 0);
      tick;
      drive_a(8'h5A, 8'h5A, 1, 0);
      tick;
      chk("pre_rst_ov", a_ov, 1);
      chk("pre_rst_cnt", a_cnt, 2);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_oq", a_oq, 8'h00);
      chk("arst_ov", a_ov, 0);
      chk("arst_eq", a_eq, 0);
      chk("arst_ones", a_ones, 0);
      chk("arst_cnt", a_cnt, 0);
      a_i1 = 8'h0F; a_i2 = 8'h0E;
      #1 chk("arst_O_live", a_o, 8'hFE);
      drive_a(8'h11, 8'h11, 1, 0);
      tick;
      chk("arst_no_pulse", a_ov, 0);
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      a_vld = 0;
      tick;
      chk("post_rst_ov", a_ov, 0);
      chk("post_rst_cnt", a_cnt, 0);

      // randomized traffic on both instances, with one mid-run reset pulse
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         #1;
         a_i1  = 8'($urandom);
         a_i2  = ($urandom_range(0, 1) == 1) ? a_i1 : (a_i1 ^ 8'($urandom));
         a_vld = ($urandom_range(0, 3) != 0);
         a_clr = ($urandom_range(0, 15) == 0);
         b_i1  = 1'($urandom);
         b_i2  = 1'($urandom);
         b_vld = ($urandom_range(0, 3) != 0);
         b_clr = ($urandom_range(0, 31) == 0);
         if (i == 300) rst_n = 1'b0;
         if (i == 302) rst_n = 1'b1;
      end
      @(negedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
